// File: rtl/hex_image_loader.sv
// Parses an "@addr / data" hex memory-image character stream and writes 32-bit words
// into instruction memory, holding the cpu in reset until the image ends.
module hex_image_loader #(
    parameter int          ADDR_W   = 12,
    parameter logic [7:0]  EOT_CHAR = 8'h04
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ch_valid,
    input  logic [7:0]        ch_data,
    output logic              ch_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] words_written,
    output logic [2:0]        state_dbg
);

    // Handshake: a character moves only in a cycle where ch_valid and ch_ready are both
    // high; ch_valid must hold ch_data steady until that cycle, ch_ready never waits on ch_valid.

    typedef enum logic [2:0] {
        S_WS   = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_CMT  = 3'd3,
        S_FIN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [1:0]        CODE_ILLEGAL = 2'd1;
    localparam logic [1:0]        CODE_DIGITS  = 2'd2;
    localparam logic [1:0]        CODE_RANGE   = 2'd3;
    localparam logic [ADDR_W:0]   ADDR_STEP    = (ADDR_W+1)'(4);

    state_t              state;
    state_t              nxt;
    logic                started;
    logic [ADDR_W-1:0]   cur_addr;
    logic                ovf;
    logic [31:0]         acc;
    logic [3:0]          cnt;
    logic [ADDR_W:0]     addr_inc;

    logic                xfer;
    logic                is_ws, is_lf, is_hex, is_us, is_slash, is_at, is_eot, is_term;
    logic [3:0]          nib;
    logic                addr_bad;
    state_t              term_nxt;

    logic [1:0]          nxt_code;
    logic                wr_issue;
    logic                addr_load;
    logic                acc_load;
    logic                acc_clear;
    logic                acc_shift;

    assign xfer     = ch_valid && ch_ready;
    assign addr_inc = {1'b0, cur_addr} + ADDR_STEP;
    assign addr_bad = ((acc >> ADDR_W) != 32'd0) || (acc[1:0] != 2'b00);

    always_comb begin
        is_lf    = (ch_data == 8'h0A);
        is_ws    = (ch_data == 8'h20) || (ch_data == 8'h09) ||
                   (ch_data == 8'h0D) || is_lf;
        is_us    = (ch_data == 8'h5F);
        is_slash = (ch_data == 8'h2F);
        is_at    = (ch_data == 8'h40);
        is_eot   = (ch_data == EOT_CHAR);
        is_term  = is_ws || is_slash || is_eot;
        is_hex   = 1'b0;
        nib      = 4'd0;
        if (ch_data >= 8'h30 && ch_data <= 8'h39) begin
            is_hex = 1'b1;
            nib    = ch_data[3:0];
        end else if ((ch_data >= 8'h41 && ch_data <= 8'h46) ||
                     (ch_data >= 8'h61 && ch_data <= 8'h66)) begin
            // 'A'/'a' carry low nibble 1, so +9 maps them to 10
            is_hex = 1'b1;
            nib    = ch_data[3:0] + 4'd9;
        end
        if (is_eot)
            term_nxt = S_FIN;
        else if (is_slash)
            term_nxt = S_CMT;
        else
            term_nxt = S_WS;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_WS;
        else
            state <= nxt;
    end

    always_comb begin
        nxt       = state;
        nxt_code  = 2'd0;
        wr_issue  = 1'b0;
        addr_load = 1'b0;
        acc_load  = 1'b0;
        acc_clear = 1'b0;
        acc_shift = 1'b0;
        if (xfer) begin
            case (state)
                S_WS: begin
                    if (is_ws) begin
                        nxt = S_WS;
                    end else if (is_hex) begin
                        nxt      = S_DATA;
                        acc_load = 1'b1;
                    end else if (is_at) begin
                        nxt       = S_ADDR;
                        acc_clear = 1'b1;
                    end else if (is_slash) begin
                        nxt = S_CMT;
                    end else if (is_eot) begin
                        nxt = S_FIN;
                    end else begin
                        nxt      = S_ERR;
                        nxt_code = CODE_ILLEGAL;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (is_hex) begin
                        if (cnt == 4'd8) begin
                            nxt      = S_ERR;
                            nxt_code = CODE_DIGITS;
                        end else begin
                            acc_shift = 1'b1;
                        end
                    end else if (is_us) begin
                        nxt = state;
                    end else if (is_term) begin
                        if (state == S_ADDR) begin
                            if (cnt == 4'd0) begin
                                nxt      = S_ERR;
                                nxt_code = CODE_ILLEGAL;
                            end else if (addr_bad) begin
                                nxt      = S_ERR;
                                nxt_code = CODE_RANGE;
                            end else begin
                                addr_load = 1'b1;
                                nxt       = term_nxt;
                            end
                        end else if (ovf) begin
                            // address space already wrapped: refuse the word
                            nxt      = S_ERR;
                            nxt_code = CODE_RANGE;
                        end else begin
                            wr_issue = 1'b1;
                            nxt      = term_nxt;
                        end
                    end else begin
                        nxt      = S_ERR;
                        nxt_code = CODE_ILLEGAL;
                    end
                end
                S_CMT: begin
                    if (is_lf)
                        nxt = S_WS;
                    else if (is_eot)
                        nxt = S_FIN;
                end
                default: nxt = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            started       <= 1'b0;
            cur_addr      <= '0;
            ovf           <= 1'b0;
            acc           <= 32'd0;
            cnt           <= 4'd0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= 32'd0;
            words_written <= '0;
            done          <= 1'b0;
            cpu_rst_n     <= 1'b0;
            err           <= 1'b0;
            err_code      <= 2'd0;
        end else begin
            started <= 1'b1;
            mem_we  <= wr_issue;
            if (wr_issue) begin
                mem_addr      <= cur_addr;
                mem_wdata     <= acc;
                cur_addr      <= addr_inc[ADDR_W-1:0];
                ovf           <= addr_inc[ADDR_W];
                words_written <= words_written + 1'b1;
            end else if (addr_load) begin
                cur_addr <= acc[ADDR_W-1:0];
                ovf      <= 1'b0;
            end
            if (acc_load) begin
                acc <= {28'd0, nib};
                cnt <= 4'd1;
            end else if (acc_clear) begin
                acc <= 32'd0;
                cnt <= 4'd0;
            end else if (acc_shift) begin
                acc <= {acc[27:0], nib};
                cnt <= cnt + 4'd1;
            end
            if (nxt == S_ERR && state != S_ERR) begin
                err      <= 1'b1;
                err_code <= nxt_code;
            end
            // FIN is entered together with the last strobe, so this lags it by one cycle
            done      <= (state == S_FIN);
            cpu_rst_n <= (state == S_FIN);
        end
    end

    always_comb begin
        ch_ready  = started && (state != S_FIN) && (state != S_ERR);
        state_dbg = state;
    end

endmodule

// File: tb/tb_hex_image_loader.sv
// Directed bench for hex_image_loader: a table of images with expected writes and final
// flags, plus hand sequences for write/done timing and reset in the middle of a token.
module tb_hex_image_loader;

    localparam int ADDR_W = 12;
    localparam int WW     = ADDR_W + 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              ch_valid = 1'b0;
    logic [7:0]        ch_data = 8'h00;
    logic              ch_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst_n;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] words_written;
    logic [2:0]        state_dbg;

    int checks = 0;
    int errors = 0;
    logic [WW-1:0] exp_q[$];

    typedef struct {
        string             img;
        int                gap;
        int                nw;
        logic [WW-1:0]     w0;
        logic [WW-1:0]     w1;
        logic [WW-1:0]     w2;
        logic              e_done;
        logic              e_err;
        logic [1:0]        e_code;
        logic [ADDR_W-1:0] e_words;
    } vec_t;

    vec_t vecs[$];

    hex_image_loader #(.ADDR_W(ADDR_W), .EOT_CHAR(8'h04)) dut (
        .clock         (clock),
        .reset         (reset),
        .ch_valid      (ch_valid),
        .ch_data       (ch_data),
        .ch_ready      (ch_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_rst_n     (cpu_rst_n),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .words_written (words_written),
        .state_dbg     (state_dbg)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input string img, input int gap, input int nw,
                                input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                                input logic [WW-1:0] w2, input logic e_done,
                                input logic e_err, input logic [1:0] e_code,
                                input int e_words);
        vec_t v;
        v.img     = img;
        v.gap     = gap;
        v.nw      = nw;
        v.w0      = w0;
        v.w1      = w1;
        v.w2      = w2;
        v.e_done  = e_done;
        v.e_err   = e_err;
        v.e_code  = e_code;
        v.e_words = ADDR_W'(e_words);
        return v;
    endfunction

    function automatic logic [WW-1:0] wr(input int a, input logic [31:0] d);
        return {ADDR_W'(a), d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the head of the expected queue
    always @(negedge clock) begin
        if (reset && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                logic [WW-1:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             mem_addr, mem_wdata, e[WW-1:32], e[31:0]);
                end
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b0;
        ch_valid = 1'b0;
        @(posedge clock); #1;
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    // '~' stands for the end-of-image character; a stalled stream is abandoned
    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            int waitc;
            c = s[i];
            if (c == 8'h7E) c = 8'h04;
            ch_data  = c;
            ch_valid = 1'b1;
            waitc    = 0;
            while (!ch_ready && waitc < 20) begin
                @(posedge clock); #1;
                waitc++;
            end
            if (!ch_ready) begin
                ch_valid = 1'b0;
                return;
            end
            @(posedge clock); #1;
            ch_valid = 1'b0;
            repeat ($urandom_range(0, gap)) begin
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ch_ready"},  64'(ch_ready),      64'd0);
        check({tag, "_mem_we"},    64'(mem_we),        64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),      64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata),     64'd0);
        check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n),     64'd0);
        check({tag, "_done"},      64'(done),          64'd0);
        check({tag, "_err"},       64'(err),           64'd0);
        check({tag, "_err_code"},  64'(err_code),      64'd0);
        check({tag, "_words"},     64'(words_written), 64'd0);
    endtask

    initial begin
        vecs.push_back(mk("1 2 3~", 0, 3, wr(0, 32'h1), wr(4, 32'h2), wr(8, 32'h3), 1, 0, 0, 3));
        vecs.push_back(mk("2010_0009 abCD // c\n7~", 3, 3, wr(0, 32'h20100009),
                          wr(4, 32'h0000ABCD), wr(8, 32'h7), 1, 0, 0, 3));
        vecs.push_back(mk("123456789 ~", 0, 0, 0, 0, 0, 0, 1, 2, 0));
        vecs.push_back(mk("@6 1~", 0, 0, 0, 0, 0, 0, 1, 3, 0));
        vecs.push_back(mk("@FFC 1 2~", 0, 1, wr(12'hFFC, 32'h1), 0, 0, 0, 1, 3, 1));
        vecs.push_back(mk("@4 20100009~", 1, 1, wr(4, 32'h20100009), 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("#", 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("_1~", 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("@ 5~", 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("@1000 5~", 0, 0, 0, 0, 0, 0, 1, 3, 0));
        vecs.push_back(mk("12@~", 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("/hello\n@10 ffffffff ~", 2, 1, wr(12'h10, 32'hFFFFFFFF), 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("ABCDEF01~", 0, 1, wr(0, 32'hABCDEF01), 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("~", 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("/ comment ~", 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("@FF8 1 2 @0 3~", 0, 3, wr(12'hFF8, 32'h1), wr(12'hFFC, 32'h2),
                          wr(0, 32'h3), 1, 0, 0, 3));

        // Reset values, then ready one clock after release
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_idle_outputs("rst");
        reset = 1'b1;
        #1;
        check("rst_release_ready_low", 64'(ch_ready), 64'd0);
        @(posedge clock); #1;
        check("rst_release_ready_high", 64'(ch_ready), 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("v%0d", i);
            do_reset();
            if (vecs[i].nw > 0) exp_q.push_back(vecs[i].w0);
            if (vecs[i].nw > 1) exp_q.push_back(vecs[i].w1);
            if (vecs[i].nw > 2) exp_q.push_back(vecs[i].w2);
            send_str(vecs[i].img, vecs[i].gap);
            repeat (4) @(posedge clock);
            #1;
            check({t, "_done"},      64'(done),          64'(vecs[i].e_done));
            check({t, "_cpu_rst_n"}, 64'(cpu_rst_n),     64'(vecs[i].e_done));
            check({t, "_err"},       64'(err),           64'(vecs[i].e_err));
            check({t, "_err_code"},  64'(err_code),      64'(vecs[i].e_code));
            check({t, "_words"},     64'(words_written), 64'(vecs[i].e_words));
            check({t, "_ch_ready"},  64'(ch_ready),      64'd0);
            check({t, "_pending"},   64'(exp_q.size()),  64'd0);
        end

        // EOT ends a data token: strobe in N+1, done/cpu_rst_n in N+2
        do_reset();
        exp_q.push_back(wr(4, 32'h20100009));
        send_str("@4 20100009~", 0);
        check("eot_we_n1",      64'(mem_we),    64'd1);
        check("eot_done_n1",    64'(done),      64'd0);
        check("eot_cpu_rst_n1", 64'(cpu_rst_n), 64'd0);
        @(posedge clock); #1;
        check("eot_we_n2",      64'(mem_we),    64'd0);
        check("eot_done_n2",    64'(done),      64'd1);
        check("eot_cpu_rst_n2", 64'(cpu_rst_n), 64'd1);

        // Reset while digits are being collected
        do_reset();
        send_str("@8 12", 0);
        reset = 1'b0;
        #1;
        check_idle_outputs("midtok");
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        exp_q.push_back(wr(0, 32'h5));
        send_str("5~", 0);
        repeat (3) @(posedge clock);
        #1;
        check("midtok_done",    64'(done),          64'd1);
        check("midtok_words",   64'(words_written), 64'd1);
        check("midtok_pending", 64'(exp_q.size()),  64'd0);

        // Reset in the cycle the strobe is raised: that write is dropped
        do_reset();
        exp_q.push_back(wr(8, 32'h1));
        send_str("@8 1 ", 0);
        check("midwr_we_before", 64'(mem_we), 64'd1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("midwr_we_dropped", 64'(mem_we),        64'd0);
        check("midwr_words",      64'(words_written), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        exp_q.push_back(wr(0, 32'h5));
        send_str("5~", 0);
        repeat (3) @(posedge clock);
        #1;
        check("midwr_done",    64'(done),         64'd1);
        check("midwr_pending", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
